mul_div_unit: RTL



---
 rtl/mul_div_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one shared shift-add / restoring-divide
// datapath, one radix-2 step per cycle, with a single-cycle path for special divides.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              sign_quo_q, sign_quo_d;
    logic              sign_rem_q, sign_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              rs1_neg, rs2_neg;
    logic [XLEN-1:0]   rs1_mag, rs2_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_result;
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_shift;
    logic              div_ge;
    logic [XLEN:0]     div_sub;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;
    assign accept   = valid_i & ready_o & ~flush_i;

    // rs1 is signed for MULH/MULHSU/DIV/REM; rs2 only for MULH/DIV/REM.
    assign rs1_neg = rs1_i[XLEN-1] & ((funct3_i == 3'b001) | (funct3_i == 3'b010) |
                                      (funct3_i == 3'b100) | (funct3_i == 3'b110));
    assign rs2_neg = rs2_i[XLEN-1] & ((funct3_i == 3'b001) |
                                      (funct3_i == 3'b100) | (funct3_i == 3'b110));
    assign rs1_mag = rs1_neg ? -rs1_i : rs1_i;
    assign rs2_mag = rs2_neg ? -rs2_i : rs2_i;

    assign div_zero = funct3_i[2] & (rs2_i == '0);
    assign div_ovf  = funct3_i[2] & ~funct3_i[0] &
                      (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = funct3_i[1] ? rs1_i : '1;
        end else if (div_ovf) begin
            special_result = funct3_i[1] ? '0 : rs1_i;
        end
    end

    // Multiply: product builds in acc_q, multiplier consumed from its LSB.
    // Divide: dividend shifts out of acc_q's low half as quotient bits shift in.
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {rem_q, acc_q[XLEN-1]};
    assign div_ge    = (div_shift >= {2'b00, b_q});
    assign div_sub   = div_shift[XLEN:0] - {1'b0, b_q};

    assign prod_fix = sign_quo_q ? -acc_q : acc_q;
    assign quo_fix  = sign_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = sign_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        fix_result = '0;
        case (funct3_q)
            3'b000:                 fix_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result = quo_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        funct3_d   = funct3_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        b_d        = b_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        result_d   = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    funct3_d   = funct3_i;
                    sign_quo_d = rs1_neg ^ rs2_neg;
                    sign_rem_d = rs1_neg;
                    acc_d      = {{XLEN{1'b0}}, rs1_mag};
                    b_d        = rs2_mag;
                    rem_d      = '0;
                    count_d    = '0;
                    if (special) begin
                        result_d = special_result;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    if (funct3_q[2]) begin
                        rem_d = div_ge ? div_sub : div_shift[XLEN:0];
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(XLEN - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    result_d = fix_result;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (flush_i || ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            funct3_q   <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            b_q        <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            funct3_q   <= funct3_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            b_q        <= b_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            result_q   <= result_d;
        end
    end
endmodule
